// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the hazard/forwarding unit.
//   - fwd_sel encoding constants (FWD_RF = register file, FWD_STGk = stage k)
//   - load-use stall FSM state type
//   - sel_width(): width of one fwd_sel field for a given stage count
package hazard_pkg;

   localparam int unsigned FWD_RF   = 0;
   localparam int unsigned FWD_STG1 = 1;
   localparam int unsigned FWD_STG2 = 2;
   localparam int unsigned FWD_STG3 = 3;
   localparam int unsigned FWD_STG4 = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      STALL = 1'b1
   } hz_state_t;

   // One extra code point is needed for "no forwarding" (FWD_RF).
   function automatic int unsigned sel_width(input int unsigned num_stages);
      return $clog2(num_stages + 1);
   endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_prio_sel.sv
// fwd_prio_sel: priority encoder choosing the forwarding source for one
// EX-stage source operand.
// Ports:
//   rs      in   source register index
//   fwd_rd  in   destination index per stage, stage k at [(k-1)*REG_AW +: REG_AW]
//   fwd_wb  in   regwrite-valid per stage, stage k at bit k-1
//   sel     out  0 = register file, k = youngest matching stage k
module fwd_prio_sel
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW         = 5,
   parameter int unsigned NUM_FWD_STAGES = 2,
   parameter int unsigned SEL_W          = sel_width(NUM_FWD_STAGES)
) (
   input  logic [REG_AW-1:0]                rs,
   input  logic [NUM_FWD_STAGES*REG_AW-1:0] fwd_rd,
   input  logic [NUM_FWD_STAGES-1:0]        fwd_wb,
   output logic [SEL_W-1:0]                 sel
);

   // Scan from oldest to youngest so the youngest match is written last.
   always_comb begin
      sel = SEL_W'(FWD_RF);
      for (int unsigned k = NUM_FWD_STAGES; k >= 1; k--) begin
         if (fwd_wb[k-1] &&
             (fwd_rd[(k-1)*REG_AW +: REG_AW] != '0) &&
             (fwd_rd[(k-1)*REG_AW +: REG_AW] == rs)) begin
            sel = SEL_W'(k);
         end
      end
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: data-hazard handling for the in-order pipeline.
//   - EX operand forwarding (combinational, youngest stage wins)
//   - load-use detection and LOAD_LAT-cycle stall FSM
//   - saturating stall-cycle counter
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   ex_rs             EX source indices, src i at [i*REG_AW +: REG_AW]
//   fwd_rd, fwd_wb    per-stage destination index and regwrite-valid
//   fwd_sel           per-source forwarding select (0 = register file)
//   id_rs, id_rs_used ID source indices and read-enables
//   ex_rd, ex_valid, ex_mem_read  EX instruction destination / valid / load
//   flush_in          redirect; suppresses detection and aborts a stall
//   stat_clr          clear stall_count
//   stall_if, stall_id, flush_ex  pipeline control
//   hazard_busy       FSM in STALL
//   stall_count       saturating count of stall cycles
module hazard_forward_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW         = 5,
   parameter int unsigned NUM_SRC        = 2,
   parameter int unsigned NUM_FWD_STAGES = 2,
   parameter int unsigned LOAD_LAT       = 1,
   parameter int unsigned CNT_W          = 16,
   localparam int unsigned SEL_W         = sel_width(NUM_FWD_STAGES)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_SRC*REG_AW-1:0]        ex_rs,
   input  logic [NUM_FWD_STAGES*REG_AW-1:0] fwd_rd,
   input  logic [NUM_FWD_STAGES-1:0]        fwd_wb,
   output logic [NUM_SRC*SEL_W-1:0]         fwd_sel,
   input  logic [NUM_SRC*REG_AW-1:0]        id_rs,
   input  logic [NUM_SRC-1:0]               id_rs_used,
   input  logic [REG_AW-1:0]                ex_rd,
   input  logic                             ex_valid,
   input  logic                             ex_mem_read,
   input  logic                             flush_in,
   input  logic                             stat_clr,
   output logic                             stall_if,
   output logic                             stall_id,
   output logic                             flush_ex,
   output logic                             hazard_busy,
   output logic [CNT_W-1:0]                 stall_count
);

   // rem holds the STALL cycles still owed, including the current one.
   localparam int unsigned REM_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

   hz_state_t        state, state_next;
   logic [REM_W-1:0] rem, rem_next;
   logic             rs_hit;
   logic             luh;
   logic             stall;

   // Forwarding selects, one priority encoder per source operand.
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_prio_sel #(
         .REG_AW         (REG_AW),
         .NUM_FWD_STAGES (NUM_FWD_STAGES),
         .SEL_W          (SEL_W)
      ) u_sel (
         .rs     (ex_rs[i*REG_AW +: REG_AW]),
         .fwd_rd (fwd_rd),
         .fwd_wb (fwd_wb),
         .sel    (fwd_sel[i*SEL_W +: SEL_W])
      );
   end

   // Load-use detection against the ID-stage sources.
   always_comb begin
      rs_hit = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (id_rs_used[i] && (id_rs[i*REG_AW +: REG_AW] == ex_rd)) begin
            rs_hit = 1'b1;
         end
      end
      luh = ex_valid && ex_mem_read && (ex_rd != '0) && !flush_in && rs_hit;
   end

   // The first stall cycle is spent in IDLE (the load is still in EX); STALL
   // covers the remaining LOAD_LAT-1 cycles.
   always_comb begin
      state_next  = state;
      rem_next    = rem;
      stall       = 1'b0;
      hazard_busy = 1'b0;
      unique case (state)
         IDLE: begin
            stall = luh;
            if (luh && (LOAD_LAT > 1)) begin
               state_next = STALL;
               rem_next   = REM_W'(LOAD_LAT - 1);
            end
         end
         STALL: begin
            stall       = 1'b1;
            hazard_busy = 1'b1;
            if (flush_in || (rem == REM_W'(1))) begin
               state_next = IDLE;
               rem_next   = '0;
            end else begin
               rem_next = rem - REM_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            rem_next   = '0;
         end
      endcase
   end

   assign stall_if = stall;
   assign stall_id = stall;
   assign flush_ex = stall;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         rem   <= '0;
      end else begin
         state <= state_next;
         rem   <= rem_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (stat_clr) begin
         stall_count <= '0;
      end else if (stall && (stall_count != '1)) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench: two instances (LOAD_LAT=1/CNT_W=4 and LOAD_LAT=3/CNT_W=16)
// share inputs; a stall-debt reference model predicts both.
module tb_hazard_forward_unit;

   localparam int unsigned AW = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  ex_rs, fwd_rd, id_rs;
   logic [1:0]  fwd_wb, id_rs_used;
   logic [4:0]  ex_rd;
   logic        ex_valid, ex_mem_read, flush_in, stat_clr;

   logic [3:0]  sel1, sel3;
   logic        sif1, sid1, fex1, busy1;
   logic        sif3, sid3, fex3, busy3;
   logic [3:0]  cnt1;
   logic [15:0] cnt3;

   int checks = 0;
   int errors = 0;

   // Reference model: cycles of stall still owed after the current cycle.
   int owed1, owed3, mcnt1, mcnt3;

   always #5 clk = ~clk;

   hazard_forward_unit #(.REG_AW(AW), .NUM_SRC(2), .NUM_FWD_STAGES(2),
                         .LOAD_LAT(1), .CNT_W(4)) u_lat1 (
      .clk(clk), .rst_n(rst_n), .ex_rs(ex_rs), .fwd_rd(fwd_rd), .fwd_wb(fwd_wb),
      .fwd_sel(sel1), .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rd(ex_rd),
      .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .flush_in(flush_in),
      .stat_clr(stat_clr), .stall_if(sif1), .stall_id(sid1), .flush_ex(fex1),
      .hazard_busy(busy1), .stall_count(cnt1));

   hazard_forward_unit #(.REG_AW(AW), .NUM_SRC(2), .NUM_FWD_STAGES(2),
                         .LOAD_LAT(3), .CNT_W(16)) u_lat3 (
      .clk(clk), .rst_n(rst_n), .ex_rs(ex_rs), .fwd_rd(fwd_rd), .fwd_wb(fwd_wb),
      .fwd_sel(sel3), .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rd(ex_rd),
      .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .flush_in(flush_in),
      .stat_clr(stat_clr), .stall_if(sif3), .stall_id(sid3), .flush_ex(fex3),
      .hazard_busy(busy3), .stall_count(cnt3));

   // Forwarding rule: smallest stage k with a valid, non-zero, matching rd.
   function automatic int ref_sel(input logic [4:0] rs);
      logic [4:0] rd;
      for (int k = 1; k <= 2; k++) begin
         rd = fwd_rd[(k-1)*AW +: AW];
         if (fwd_wb[k-1] && rd != 5'd0 && rd == rs) return k;
      end
      return 0;
   endfunction

   function automatic logic ref_luh();
      logic hit;
      hit = (id_rs_used[0] && id_rs[4:0] == ex_rd) ||
            (id_rs_used[1] && id_rs[9:5] == ex_rd);
      return ex_valid && ex_mem_read && ex_rd != 5'd0 && !flush_in && hit;
   endfunction

   function automatic logic ref_stall(input int owed);
      return (owed > 0) || ref_luh();
   endfunction

   task automatic adv(inout int owed, inout int cnt, input int lat, input int maxc);
      logic st;
      st = ref_stall(owed);
      if (!rst_n) begin
         owed = 0;
         cnt  = 0;
      end else begin
         if (stat_clr) cnt = 0;
         else if (st && cnt < maxc) cnt++;
         if (owed > 0) owed = flush_in ? 0 : owed - 1;
         else if (ref_luh()) owed = lat - 1;
      end
   endtask

   // Advance one clock: model follows the inputs seen at the edge.
   task automatic tick();
      @(posedge clk);
      adv(owed1, mcnt1, 1, 15);
      adv(owed3, mcnt3, 3, 65535);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      ex_rs = '0; fwd_rd = '0; fwd_wb = '0; id_rs = '0; id_rs_used = '0;
      ex_rd = '0; ex_valid = 1'b0; ex_mem_read = 1'b0; flush_in = 1'b0;
      stat_clr = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic set_load_hazard();
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3;
      id_rs = {5'd3, 5'd9}; id_rs_used = 2'b10;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({sif1, sid1, fex1, busy1, sif3, sid3, fex3, busy3} !== 8'h00) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000000",
                  {sif1, sid1, fex1, busy1, sif3, sid3, fex3, busy3});
      end
      checks++;
      if (cnt1 !== 4'd0 || cnt3 !== 16'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d/%0d expected 0/0", cnt1, cnt3);
      end
   endtask

   task automatic test_forwarding();
      clear_inputs();
      ex_rs = {5'd0, 5'd5}; fwd_rd = {5'd5, 5'd5}; fwd_wb = 2'b11;
      #1;
      checks++;
      if (sel1[1:0] !== 2'd1) begin
         errors++; $display("FAIL fwd_youngest: got %0d expected 1", sel1[1:0]);
      end
      fwd_wb = 2'b10;
      #1;
      checks++;
      if (sel1[1:0] !== 2'd2) begin
         errors++; $display("FAIL fwd_older: got %0d expected 2", sel1[1:0]);
      end
      fwd_rd = {5'd5, 5'd0}; fwd_wb = 2'b01;
      #1;
      checks++;
      if (sel1[3:2] !== 2'd0) begin
         errors++; $display("FAIL fwd_r0: got %0d expected 0", sel1[3:2]);
      end
      ex_rs = {5'd0, 5'd7}; fwd_rd = {5'd5, 5'd6}; fwd_wb = 2'b11;
      #1;
      checks++;
      if (sel1[1:0] !== 2'd0) begin
         errors++; $display("FAIL fwd_nomatch: got %0d expected 0", sel1[1:0]);
      end
      ex_rs = {5'd4, 5'd4}; fwd_rd = {5'd9, 5'd4}; fwd_wb = 2'b01;
      #1;
      checks++;
      if (sel1 !== 4'b0101) begin
         errors++; $display("FAIL fwd_shared: got %b expected 0101", sel1);
      end
      for (int n = 0; n < 60; n++) begin
         ex_rs  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         fwd_rd = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         fwd_wb = 2'($urandom);
         #1;
         checks++;
         if (int'(sel1[1:0]) != ref_sel(ex_rs[4:0]) || int'(sel1[3:2]) != ref_sel(ex_rs[9:5]) ||
             sel3 !== sel1) begin
            errors++;
            $display("FAIL fwd_random: got %b/%b expected %0d,%0d", sel1, sel3,
                     ref_sel(ex_rs[9:5]), ref_sel(ex_rs[4:0]));
         end
      end
   endtask

   task automatic test_load_use_lat1();
      do_reset();
      set_load_hazard();
      #1;
      checks++;
      if ({sif1, sid1, fex1} !== 3'b111) begin
         errors++; $display("FAIL lat1_stall: got %b expected 111", {sif1, sid1, fex1});
      end
      tick();
      clear_inputs();
      #1;
      checks++;
      if ({sif1, sid1, fex1} !== 3'b000 || cnt1 !== 4'd1) begin
         errors++;
         $display("FAIL lat1_release: got ctrl=%b cnt=%0d expected 000 cnt=1",
                  {sif1, sid1, fex1}, cnt1);
      end
      set_load_hazard();
      id_rs_used = 2'b01;
      #1;
      checks++;
      if ({sif1, sid1, fex1} !== 3'b000) begin
         errors++; $display("FAIL lat1_unused: got %b expected 000", {sif1, sid1, fex1});
      end
      tick();
   endtask

   task automatic test_load_use_lat3();
      logic [3:0] exp_st = 4'b0111;
      logic [3:0] exp_bz = 4'b0110;
      do_reset();
      set_load_hazard();
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (sid3 !== exp_st[c] || sif3 !== exp_st[c] || fex3 !== exp_st[c] ||
             busy3 !== exp_bz[c]) begin
            errors++;
            $display("FAIL lat3_cycle%0d: got stall=%b busy=%b expected %b/%b",
                     c + 1, sid3, busy3, exp_st[c], exp_bz[c]);
         end
         tick();
         clear_inputs();
      end
      checks++;
      if (cnt3 !== 16'd3) begin
         errors++; $display("FAIL lat3_count: got %0d expected 3", cnt3);
      end
   endtask

   task automatic test_flush_mid_stall();
      do_reset();
      set_load_hazard();
      tick();
      clear_inputs();
      flush_in = 1'b1;
      #1;
      checks++;
      if (sid3 !== 1'b1 || busy3 !== 1'b1) begin
         errors++; $display("FAIL flush_same_cycle: got %b/%b expected 1/1", sid3, busy3);
      end
      tick();
      flush_in = 1'b0;
      #1;
      checks++;
      if (sid3 !== 1'b0 || busy3 !== 1'b0 || cnt3 !== 16'd2) begin
         errors++;
         $display("FAIL flush_idle: got stall=%b busy=%b cnt=%0d expected 0/0/2",
                  sid3, busy3, cnt3);
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_load_hazard();
      tick();
      clear_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      checks++;
      if ({sif3, sid3, fex3, busy3} !== 4'b0000 || cnt3 !== 16'd0) begin
         errors++;
         $display("FAIL reset_mid_stall: got ctrl=%b cnt=%0d expected 0000 cnt=0",
                  {sif3, sid3, fex3, busy3}, cnt3);
      end
   endtask

   task automatic test_back_to_back_saturation();
      do_reset();
      set_load_hazard();
      for (int c = 0; c < 20; c++) tick();
      #1;
      checks++;
      if (cnt1 !== 4'd15) begin
         errors++; $display("FAIL sat_count: got %0d expected 15", cnt1);
      end
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      clear_inputs();
      #1;
      checks++;
      if (cnt1 !== 4'd0) begin
         errors++; $display("FAIL clr_wins: got %0d expected 0", cnt1);
      end
   endtask

   task automatic test_random();
      logic es1, es3;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         ex_rs       = 10'($urandom);
         fwd_rd      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         fwd_wb      = 2'($urandom);
         id_rs       = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         id_rs_used  = 2'($urandom);
         ex_rd       = 5'($urandom_range(0, 3));
         ex_valid    = ($urandom_range(0, 3) != 0);
         ex_mem_read = ($urandom_range(0, 1) != 0);
         flush_in    = ($urandom_range(0, 9) == 0);
         stat_clr    = ($urandom_range(0, 39) == 0);
         rst_n       = ($urandom_range(0, 79) != 0);
         #1;
         es1 = ref_stall(owed1);
         es3 = ref_stall(owed3);
         checks++;
         if ({sif1, sid1, fex1} !== {3{es1}} || busy1 !== (owed1 > 0) ||
             int'(cnt1) != mcnt1) begin
            errors++;
            $display("FAIL rand_lat1 n=%0d: got ctrl=%b busy=%b cnt=%0d expected %b/%b/%0d",
                     n, {sif1, sid1, fex1}, busy1, cnt1, es1, owed1 > 0, mcnt1);
         end
         checks++;
         if ({sif3, sid3, fex3} !== {3{es3}} || busy3 !== (owed3 > 0) ||
             int'(cnt3) != mcnt3) begin
            errors++;
            $display("FAIL rand_lat3 n=%0d: got ctrl=%b busy=%b cnt=%0d expected %b/%b/%0d",
                     n, {sif3, sid3, fex3}, busy3, cnt3, es3, owed3 > 0, mcnt3);
         end
         checks++;
         if (int'(sel3[1:0]) != ref_sel(ex_rs[4:0]) || int'(sel3[3:2]) != ref_sel(ex_rs[9:5])) begin
            errors++;
            $display("FAIL rand_fwd n=%0d: got %b expected %0d,%0d", n, sel3,
                     ref_sel(ex_rs[9:5]), ref_sel(ex_rs[4:0]));
         end
         tick();
      end
      rst_n = 1'b1;
   endtask

   initial begin
      owed1 = 0; owed3 = 0; mcnt1 = 0; mcnt3 = 0;
      rst_n = 1'b0;
      clear_inputs();
      @(negedge clk);
      test_reset();
      test_forwarding();
      test_load_use_lat1();
      test_load_use_lat3();
      test_flush_mid_stall();
      test_reset_mid_stall();
      test_back_to_back_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
